// File: rtl/aes_round_pipe.sv
// Elastic single-round AES engine: S1 SubBytes/ShiftRows, optional S2 MixColumns register, S3 AddRoundKey.
// Define AES_ROUND_INV_EN to add the equivalent-inverse round, selected per state by round_inv.
module aes_round_pipe #(
    parameter int TAG_W   = 4,
    parameter int MIX_REG = 1
) (
    input  logic             round_clk,
    input  logic             round_rst_n,
    input  logic             round_flush,
    input  logic             round_datain_valid,
    output logic             round_datain_ready,
    input  logic [127:0]     round_datain,
    input  logic [127:0]     round_keyin,
    input  logic             round_last,
    input  logic             round_inv,
    input  logic [TAG_W-1:0] round_tagin,
    output logic             round_dataout_valid,
    input  logic             round_dataout_ready,
    output logic [127:0]     round_dataout,
    output logic [TAG_W-1:0] round_tagout,
    output logic             round_busy
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

`ifdef AES_ROUND_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction
`endif

    logic               s1_valid, s1_last, s1_inv;
    logic [127:0]       s1_data, s1_key;
    logic [TAG_W-1:0]   s1_tag;
    logic               s1_ready, s1_adv, s3_ready;
    logic               mid_valid, s2_busy;
    logic [127:0]       mid_state, mid_key;
    logic [TAG_W-1:0]   mid_tag;
    logic [127:0]       sub_inv, sub_next, mix_inv, mix_out;
    logic               in_inv;

`ifdef AES_ROUND_INV_EN
    localparam logic INV_EN = 1'b1;
    assign sub_inv = inv_sub_shift(round_datain);
    assign mix_inv = inv_mix_columns(s1_data);
`else
    localparam logic INV_EN = 1'b0;
    assign sub_inv = '0;
    assign mix_inv = '0;
`endif

    assign in_inv   = round_inv & INV_EN;
    assign sub_next = in_inv ? sub_inv : sub_shift(round_datain);
    assign mix_out  = s1_last ? s1_data : (s1_inv ? mix_inv : mix_columns(s1_data));

    // Ready chain: a stage may load when empty or when its contents leave this edge.
    assign s3_ready            = !s3_valid_q() || round_dataout_ready;
    assign s1_ready            = !s1_valid || s1_adv;
    assign round_datain_ready  = s1_ready && !round_flush;
    assign round_busy          = s1_valid | s2_busy | round_dataout_valid;

    function automatic logic s3_valid_q();
        return round_dataout_valid;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge round_clk or negedge round_rst_n) begin
        if (!round_rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_data  <= '0;
            s1_key   <= '0;
            s1_tag   <= '0;
        end else if (round_flush) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= round_datain_valid;
            if (round_datain_valid) begin
                s1_data <= sub_next;
                s1_key  <= round_keyin;
                s1_last <= round_last;
                s1_inv  <= in_inv;
                s1_tag  <= round_tagin;
            end
        end
    end

    generate
        if (MIX_REG != 0) begin : g_mix_reg
            logic               s2_valid;
            logic [127:0]       s2_data, s2_key;
            logic [TAG_W-1:0]   s2_tag;

            always_ff @(posedge round_clk or negedge round_rst_n) begin
                if (!round_rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_key   <= '0;
                    s2_tag   <= '0;
                end else if (round_flush) begin
                    s2_valid <= 1'b0;
                end else if (!s2_valid || s3_ready) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= mix_out;
                        s2_key  <= s1_key;
                        s2_tag  <= s1_tag;
                    end
                end
            end

            assign s1_adv    = !s2_valid || s3_ready;
            assign s2_busy   = s2_valid;
            assign mid_valid = s2_valid;
            assign mid_state = s2_data;
            assign mid_key   = s2_key;
            assign mid_tag   = s2_tag;
        end else begin : g_mix_comb
            assign s1_adv    = s3_ready;
            assign s2_busy   = 1'b0;
            assign mid_valid = s1_valid;
            assign mid_state = mix_out;
            assign mid_key   = s1_key;
            assign mid_tag   = s1_tag;
        end
    endgenerate

    // Flush only drops valids; data registers keep stale contents that nothing observes.
    always_ff @(posedge round_clk or negedge round_rst_n) begin
        if (!round_rst_n) begin
            round_dataout_valid <= 1'b0;
            round_dataout       <= '0;
            round_tagout        <= '0;
        end else if (round_flush) begin
            round_dataout_valid <= 1'b0;
        end else if (s3_ready) begin
            round_dataout_valid <= mid_valid;
            if (mid_valid) begin
                round_dataout <= mid_state ^ mid_key;
                round_tagout  <= mid_tag;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Directed bench for aes_round_pipe: dut_a (MIX_REG=1, latency 3) and dut_b (MIX_REG=0, latency 2) share data inputs.
module tb_aes_round_pipe;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             round_flush;
    logic [127:0]     round_datain, round_keyin;
    logic             round_last, round_inv;
    logic [TAG_W-1:0] round_tagin;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic             out_ready [2];
    logic             dout_valid[2];
    logic [127:0]     dout      [2];
    logic [TAG_W-1:0] tagout    [2];
    logic             busy      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_round_pipe #(.TAG_W(TAG_W), .MIX_REG(1)) dut_a (
        .round_clk(clk), .round_rst_n(rst_n), .round_flush(round_flush),
        .round_datain_valid(in_valid[0]), .round_datain_ready(in_ready[0]),
        .round_datain(round_datain), .round_keyin(round_keyin), .round_last(round_last),
        .round_inv(round_inv), .round_tagin(round_tagin),
        .round_dataout_valid(dout_valid[0]), .round_dataout_ready(out_ready[0]),
        .round_dataout(dout[0]), .round_tagout(tagout[0]), .round_busy(busy[0])
    );

    aes_round_pipe #(.TAG_W(TAG_W), .MIX_REG(0)) dut_b (
        .round_clk(clk), .round_rst_n(rst_n), .round_flush(round_flush),
        .round_datain_valid(in_valid[1]), .round_datain_ready(in_ready[1]),
        .round_datain(round_datain), .round_keyin(round_keyin), .round_last(round_last),
        .round_inv(round_inv), .round_tagin(round_tagin),
        .round_dataout_valid(dout_valid[1]), .round_dataout_ready(out_ready[1]),
        .round_dataout(dout[1]), .round_tagout(tagout[1]), .round_busy(busy[1])
    );

    // One transfer into DUT d, then wait (bounded) for its result; lat counts negedges after the transfer edge.
    task automatic run_single(input int d, input logic [127:0] data, input logic [127:0] key,
                              input logic last, input logic inv, input logic [TAG_W-1:0] tag,
                              output logic [127:0] got, output logic [TAG_W-1:0] got_tag, output int lat);
        int guard;
        @(negedge clk);
        round_datain = data; round_keyin = key; round_last = last; round_inv = inv; round_tagin = tag;
        in_valid[d] = 1'b1; out_ready[d] = 1'b1;
        #1;
        guard = 0;
        while (!in_ready[d] && guard < 10) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 1;
        #1;
        while (!dout_valid[d] && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        got = dout[d];
        got_tag = tagout[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; round_flush = 1'b0;
        round_datain = '0; round_keyin = '0; round_last = 1'b0; round_inv = 1'b0; round_tagin = '0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            checks++; if (dout[d] !== 128'h0) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0", d, dout[d]); end
            checks++; if (tagout[d] !== '0) begin errors++; $display("FAIL reset_tag[%0d]: got %h want 0", d, tagout[d]); end
            checks++; if (dout_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, dout_valid[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", d, in_ready[d]); end
        end
    endtask

    task automatic test_fips_round();
        logic [127:0] got; logic [TAG_W-1:0] gtag; int lat;
        for (int d = 0; d < 2; d++) begin
            run_single(d, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'ha0fafe1788542cb123a339392a6c7605,
                       1'b0, 1'b0, 4'h9, got, gtag, lat);
            checks++; if (got !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin errors++; $display("FAIL fips_data[%0d]: got %h want a49c7ff2689f352b6b5bea43026a5049", d, got); end
            checks++; if (gtag !== 4'h9) begin errors++; $display("FAIL fips_tag[%0d]: got %h want 9", d, gtag); end
            checks++; if (lat !== 3 - d) begin errors++; $display("FAIL fips_latency[%0d]: got %0d want %0d", d, lat, 3 - d); end
        end
    endtask

    task automatic test_final_round();
        logic [127:0] got; logic [TAG_W-1:0] gtag; int lat;
        for (int d = 0; d < 2; d++) begin
            run_single(d, 128'heb40f21e592e38848ba113e71bc342d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                       1'b1, 1'b0, 4'h6, got, gtag, lat);
            checks++; if (got !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL final_data[%0d]: got %h want 3925841d02dc09fbdc118597196a0b32", d, got); end
            checks++; if (gtag !== 4'h6) begin errors++; $display("FAIL final_tag[%0d]: got %h want 6", d, gtag); end
        end
    endtask

    task automatic test_zero_state();
        logic [127:0] got; logic [TAG_W-1:0] gtag; int lat;
        run_single(0, 128'h0, 128'h0, 1'b1, 1'b0, 4'h0, got, gtag, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL zero_valid: latency %0d want 3", lat); end
        checks++; if (got !== {16{8'h63}}) begin errors++; $display("FAIL zero_data: got %h want 6363..63", got); end
    endtask

    task automatic test_inverse();
        logic [127:0] got; logic [TAG_W-1:0] gtag; int lat;
        logic [127:0] expv;
`ifdef AES_ROUND_INV_EN
        expv = 128'heb40f21e592e38848ba113e71bc342d2;
`else
        expv = 128'h1e23a7221f31c5d52701ff4079c771cf;
`endif
        run_single(0, 128'he9317db5cb322c723d2e895faf090794, 128'h0, 1'b1, 1'b1, 4'h3, got, gtag, lat);
        checks++; if (got !== expv) begin errors++; $display("FAIL inverse_data: got %h want %h", got, expv); end
        checks++; if (gtag !== 4'h3) begin errors++; $display("FAIL inverse_tag: got %h want 3", gtag); end
    endtask

    // Six zero states with key {16{i}} and last=1 give {16{63^i}}; output is held off for 5 cycles mid-stream.
    task automatic test_backpressure(input int d);
        int  got_n;
        bit  saw_drop;
        got_n = 0; saw_drop = 1'b0;
        round_datain = '0; round_last = 1'b1; round_inv = 1'b0;
        fork
            begin : producer
                int i, guard;
                i = 0; guard = 0;
                while (i < 6 && guard < 60) begin
                    @(negedge clk);
                    in_valid[d] = 1'b1;
                    round_keyin = {16{8'(i)}};
                    round_tagin = 4'(i);
                    #1;
                    if (in_ready[d]) i++;
                    else saw_drop = 1'b1;
                    guard++;
                end
                @(negedge clk);
                in_valid[d] = 1'b0;
            end
            begin : consumer
                int cyc;
                logic stalled;
                logic [127:0] held, expv;
                logic [TAG_W-1:0] held_tag;
                cyc = 0; stalled = 1'b0; held = '0; held_tag = '0;
                while (got_n < 6 && cyc < 60) begin
                    @(negedge clk);
                    out_ready[d] = !(cyc >= 4 && cyc < 9);
                    #1;
                    if (dout_valid[d]) begin
                        if (stalled) begin
                            checks++;
                            if (dout[d] !== held || tagout[d] !== held_tag) begin
                                errors++; $display("FAIL bp_hold[%0d]: got %h/%h want %h/%h", d, dout[d], tagout[d], held, held_tag);
                            end
                        end
                        if (out_ready[d]) begin
                            expv = {16{8'h63 ^ 8'(got_n)}};
                            checks++;
                            if (dout[d] !== expv || tagout[d] !== 4'(got_n)) begin
                                errors++; $display("FAIL bp_out[%0d] #%0d: got %h/%h want %h/%h", d, got_n, dout[d], tagout[d], expv, 4'(got_n));
                            end
                            got_n++;
                            stalled = 1'b0;
                        end else begin
                            stalled = 1'b1; held = dout[d]; held_tag = tagout[d];
                        end
                    end
                    cyc++;
                end
                out_ready[d] = 1'b1;
            end
        join
        checks++; if (got_n !== 6) begin errors++; $display("FAIL bp_count[%0d]: got %0d want 6", d, got_n); end
        checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL bp_ready_drop[%0d]: got %b want 1", d, saw_drop); end
        @(negedge clk);
        #1;
        checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL bp_drain[%0d]: busy %b want 0", d, busy[d]); end
    endtask

    task automatic fill_three(input int d);
        out_ready[d] = 1'b0;
        round_datain = '0; round_keyin = '0; round_last = 1'b1; round_inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid[d] = 1'b1; round_tagin = 4'(i + 10);
        end
    endtask

    task automatic test_flush();
        int seen;
        fill_three(0);
        @(negedge clk);
        round_flush = 1'b1;
        #1;
        checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready[0]); end
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", busy[0]); end
        @(negedge clk);
        round_flush = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        #1;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", busy[0]); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (dout_valid[0]) seen++;
            @(negedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen;
        fill_three(0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        checks++; if (dout_valid[0] !== 1'b1) begin errors++; $display("FAIL rstmid_valid_before: got %b want 1", dout_valid[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dout[0] !== 128'h0) begin errors++; $display("FAIL rstmid_dout: got %h want 0", dout[0]); end
        checks++; if (tagout[0] !== '0) begin errors++; $display("FAIL rstmid_tag: got %h want 0", tagout[0]); end
        checks++; if (dout_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b/%b want 0/0", dout_valid[0], busy[0]); end
        @(negedge clk);
        rst_n = 1'b1; out_ready[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (dout_valid[0] || busy[0]) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_after: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_fips_round();
        test_final_round();
        test_zero_state();
        test_inverse();
        test_backpressure(0);
        test_backpressure(1);
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_round_pipe.md
# aes_round_pipe

Parametrised, elastic AES round engine: one full AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) per accepted 128-bit state, with valid/ready flow control on both sides. It carries the round key, a last-round flag and a user tag alongside each state, so it can be driven by a round-iterating controller or chained to form an unrolled cipher. It adds the final-round MixColumns bypass, backpressure, flush, configurable pipeline depth and an optional inverse (decrypt) round.

## Interface
- TAG_W, 4: width of the sideband tag carried with each state (≥1).
- MIX_REG, 1: 1 = register after MixColumns (latency 3); 0 = MixColumns and AddRoundKey share one stage (latency 2).
- round_clk  in  1  clock; all state changes on rising edge.
- round_rst_n  in  1  reset; asynchronous, active-low.
- round_flush  in  1  synchronous clear of all stage valids.
- round_datain_valid  in  1  input state present.
- round_datain_ready  out  1  engine accepts the input this cycle.
- round_datain  in  128  state; byte 0 (row 0, col 0) = [127:120], column-major.
- round_keyin  in  128  round key, captured with the state.
- round_last  in  1  final round: skip MixColumns.
- round_inv  in  1  inverse round select (see Configuration).
- round_tagin  in  TAG_W  sideband tag.
- round_dataout_valid  out  1  output state present.
- round_dataout_ready  in  1  downstream accepts the output.
- round_dataout  out  128  round result.
- round_tagout  out  TAG_W  tag of round_dataout.
- round_busy  out  1  any stage holds valid data.

## Operation
- Transfer occurs when valid && ready on a side in the same cycle.
- Stage S1: on input transfer, register SubBytes(ShiftRows(datain)) plus key, last, inv, tag.
- Stage S2 (MIX_REG=1): register MixColumns(S1) (or S1 unchanged if last) plus sideband.
- Stage S3: register S2 (or MixColumns/bypass of S1 when MIX_REG=0) XOR carried key; drives outputs.
- Each stage keeps a valid bit; a stage loads when it is empty or its contents leave in the same cycle. round_datain_ready = S1 empty or S1 advancing; computed combinationally from round_dataout_ready (ready chain, no skid buffer).
- Stage valid is set only by an upstream transfer, never by data content; all-zero states are legal.
- Stalled stages hold data and sideband unchanged; output stable while valid && !ready.
- round_flush: all valids cleared next edge; input not accepted that cycle (round_datain_ready = 0); data registers may keep stale values.
- round_busy = OR of stage valids.

## Timing
- Reset (async assert): all valids 0, round_dataout = 0, round_tagout = 0, round_dataout_valid = 0, round_busy = 0; round_datain_ready = 1 once reset released (flush low).
- Reset release synchronous to round_clk; first accept on first edge with round_rst_n high.
- Latency: 2+MIX_REG cycles from input transfer to round_dataout_valid, with no stall.
- Throughput: one state per cycle with round_dataout_ready held 1.
- Full pipeline with round_dataout_ready = 0: round_datain_ready = 0; no state is dropped or duplicated.
- Output taken and new input accepted on the same edge while full: both occur.
- Reset mid-operation: all in-flight states discarded, no output valid after reset.

## Configuration
- AES_ROUND_INV_EN defined: round_inv = 1 selects the equivalent-inverse round: InvSubBytes, InvShiftRows, InvMixColumns (skipped if last), AddRoundKey. Key must already be InvMixColumns-transformed by the key schedule for middle rounds. Selection is per state, carried through the pipe.
- Not defined: inverse S-box and InvMixColumns logic are absent; round_inv port exists but is ignored (treated 0).

## Test plan
- FIPS-197 App. B round 1: datain 193de3bea0f4e22b9ac68d2ae9f84808, key a0fafe1788542cb123a339392a6c7605, last=0 -> after 3 cycles (MIX_REG=1) dataout a49c7ff2689f352b6b5bea43026a5049, tag echoed.
- Final round: datain eb40f21e592e38848ba113e71bc342d2, key d014f9a8c9ee2589e13f0cc8b6630ca6, last=1 -> dataout 3925841d02dc09fbdc118597196a0b32.
- Backpressure: stream 6 tagged states 0..5, hold round_dataout_ready=0 for 5 cycles mid-stream -> datain_ready drops after pipe fills, all 6 outputs arrive in order, unchanged while stalled; MIX_REG=0 repeats with latency 2.
- Zero state: datain 0, key 0, last=1 -> dataout_valid asserts with 636363…63 (16 bytes).
- Flush/reset: assert round_flush with 3 states in flight -> no outputs, busy=0 next cycle; assert round_rst_n=0 mid-stream -> outputs 0 immediately, no valid after release.
- AES_ROUND_INV_EN: datain = 3925841d…0b32 XOR d014f9a8…0ca6, key 0, inv=1, last=1 -> dataout eb40f21e592e38848ba113e71bc342d2; without macro same stimulus yields forward-round result.
